jtag_tap_ctrl: RTL

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_pkg.sv | 56 +++++
 rtl/jtag_tap_fsm.sv | 37 +++
 rtl/jtag_tap_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types and constants: TAP state encoding, instruction
// encoding, IR capture pattern and the default IDCODE value.
package jtag_pkg;

  localparam int unsigned MSB_IR_ENC = 3;

  // Pattern loaded into the IR shift register in CAPTURE_IR (LSBs 01 as required)
  localparam logic [MSB_IR_ENC:0] IR_CAPTURE_VAL = 4'b0101;

  localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0001;

  typedef enum logic [3:0] {
    TestLogicReset = 4'h0,
    RunTestIdle    = 4'h1,
    SelectDrScan   = 4'h2,
    CaptureDr      = 4'h3,
    ShiftDr        = 4'h4,
    Exit1Dr        = 4'h5,
    PauseDr        = 4'h6,
    Exit2Dr        = 4'h7,
    UpdateDr       = 4'h8,
    SelectIrScan   = 4'h9,
    CaptureIr      = 4'ha,
    ShiftIr        = 4'hb,
    Exit1Ir        = 4'hc,
    PauseIr        = 4'hd,
    Exit2Ir        = 4'he,
    UpdateIr       = 4'hf
  } tap_ctrl_fsm_t;

  typedef enum logic [MSB_IR_ENC:0] {
    Extest        = 4'h0,
    SamplePreload = 4'h1,
    Idcode        = 4'he,
    Bypass        = 4'hf
  } ir_decoding_t;

  // Which data register sits between tdi and tdo
  typedef enum logic [1:0] {
    DrBypass,
    DrIdcode,
    DrExt
  } dr_sel_t;

  // Anything not explicitly decoded falls back to the bypass register
  function automatic dr_sel_t decode_dr(input logic [MSB_IR_ENC:0] ir);
    dr_sel_t sel;
    case (ir)
      Idcode:                sel = DrIdcode;
      Extest, SamplePreload: sel = DrExt;
      default:               sel = DrBypass;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine, advanced on tck rise.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic          tck,
  input  logic          trst,
  input  logic          tms,
  output tap_ctrl_fsm_t state
);

  // Standard 16-state TAP transition graph; tms=1 five times always reaches reset
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state <= TestLogicReset;
    end else begin
      unique case (state)
        TestLogicReset: state <= tms ? TestLogicReset : RunTestIdle;
        RunTestIdle:    state <= tms ? SelectDrScan   : RunTestIdle;
        SelectDrScan:   state <= tms ? SelectIrScan   : CaptureDr;
        CaptureDr:      state <= tms ? Exit1Dr        : ShiftDr;
        ShiftDr:        state <= tms ? Exit1Dr        : ShiftDr;
        Exit1Dr:        state <= tms ? UpdateDr       : PauseDr;
        PauseDr:        state <= tms ? Exit2Dr        : PauseDr;
        Exit2Dr:        state <= tms ? UpdateDr       : ShiftDr;
        UpdateDr:       state <= tms ? SelectDrScan   : RunTestIdle;
        SelectIrScan:   state <= tms ? TestLogicReset : CaptureIr;
        CaptureIr:      state <= tms ? Exit1Ir        : ShiftIr;
        ShiftIr:        state <= tms ? Exit1Ir        : ShiftIr;
        Exit1Ir:        state <= tms ? UpdateIr       : PauseIr;
        PauseIr:        state <= tms ? Exit2Ir        : PauseIr;
        Exit2Ir:        state <= tms ? UpdateIr       : ShiftIr;
        UpdateIr:       state <= tms ? SelectDrScan   : RunTestIdle;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: instruction register, BYPASS and IDCODE data registers,
// strobes for external data registers and the tdo output mux.
// Optional macro JTAG_TDO_NEGEDGE_EN: register tdo on the falling edge of tck.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter logic [31:0]  IDCODE_VAL = IDCODE_DEFAULT,
  parameter ir_decoding_t IR_RST_VAL = Idcode
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic [3:0]            tap_state_o,
  output logic [MSB_IR_ENC:0]   ir_o,
  output logic                  capture_dr_o,
  output logic                  shift_dr_o,
  output logic                  update_dr_o,
  input  logic                  ext_tdo_i
);

  tap_ctrl_fsm_t         state;
  logic [MSB_IR_ENC:0]   ir_shift;
  logic [MSB_IR_ENC:0]   ir_q;
  logic                  bypass_q;
  logic [31:0]           idcode_q;
  dr_sel_t               dr_sel;
  logic                  tdo_mux;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (state)
  );

  assign tap_state_o = state;

  // Force the reset instruction for the whole time the TAP sits in reset,
  // including the first cycle after entering it through tms
  assign ir_o   = (state == TestLogicReset) ? IR_RST_VAL : ir_q;
  assign dr_sel = decode_dr(ir_o);

  // Instruction register: capture/shift chain and the active instruction
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift <= '0;
      ir_q     <= IR_RST_VAL;
    end else begin
      case (state)
        CaptureIr: ir_shift <= IR_CAPTURE_VAL;
        ShiftIr:   ir_shift <= {tdi, ir_shift[MSB_IR_ENC:1]};
        default:   ;
      endcase
      if (state == TestLogicReset) begin
        ir_q <= IR_RST_VAL;
      end else if (state == UpdateIr) begin
        ir_q <= ir_shift;
      end
    end
  end

  // BYPASS and IDCODE data registers; only the selected one captures or shifts
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_q <= 1'b0;
      idcode_q <= IDCODE_VAL;
    end else if (state == CaptureDr) begin
      if (dr_sel == DrBypass) bypass_q <= 1'b0;
      if (dr_sel == DrIdcode) idcode_q <= IDCODE_VAL;
    end else if (state == ShiftDr) begin
      if (dr_sel == DrBypass) bypass_q <= tdi;
      if (dr_sel == DrIdcode) idcode_q <= {tdi, idcode_q[31:1]};
    end
  end

  // External DR strobes; state values are distinct so at most one is high
  assign capture_dr_o = (state == CaptureDr) && (dr_sel == DrExt);
  assign shift_dr_o   = (state == ShiftDr)   && (dr_sel == DrExt);
  assign update_dr_o  = (state == UpdateDr)  && (dr_sel == DrExt);

  // Serial output source selection
  always_comb begin
    tdo_mux = 1'b0;
    case (state)
      ShiftIr: tdo_mux = ir_shift[0];
      ShiftDr: begin
        case (dr_sel)
          DrIdcode: tdo_mux = idcode_q[0];
          DrExt:    tdo_mux = ext_tdo_i;
          default:  tdo_mux = bypass_q;
        endcase
      end
      default: tdo_mux = 1'b0;
    endcase
  end

`ifdef JTAG_TDO_NEGEDGE_EN
  logic tdo_q;

  // Launch tdo on the falling edge so it is stable at the next capture edge
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= tdo_mux;
    end
  end

  assign tdo = tdo_q;
`else
  assign tdo = tdo_mux;
`endif

endmodule
